// File: rtl/output_driver_cfg_sequencer_if.sv
// Request, pattern-RAM and CSR-write signals between firmware/EVR control and the cfg sequencer.
// Latency: none, wires only.
// Backpressure: none in the bundle; requests while busy are refused by the sequencer with cfgError.
interface output_driver_cfg_sequencer_if #(
    parameter int SERDES_WIDTH          = 4,
    parameter int COARSE_DELAY_WIDTH    = 22,
    parameter int COARSE_WIDTH_WIDTH    = 22,
    parameter int PATTERN_ADDRESS_WIDTH = 12
);
    logic                             cfgStart;
    logic [1:0]                       cfgMode;
    logic [COARSE_DELAY_WIDTH-1:0]    cfgCoarseDelay;
    logic [SERDES_WIDTH-1:0]          cfgFirstPattern;
    logic [COARSE_WIDTH_WIDTH-1:0]    cfgCoarseWidth;
    logic [SERDES_WIDTH-1:0]          cfgLastPattern;
    logic [PATTERN_ADDRESS_WIDTH:0]   cfgPatternLength;
    logic                             cfgBusy;
    logic                             cfgDone;
    logic                             cfgError;
    logic [PATTERN_ADDRESS_WIDTH-1:0] patRdAddr;
    logic [SERDES_WIDTH-1:0]          patRdData;
    logic                             csrStrobe;
    logic [31:0]                      csrData;

    // Requester side: issues requests, supplies pattern RAM data, consumes CSR writes.
    modport master (
        output cfgStart, cfgMode, cfgCoarseDelay, cfgFirstPattern, cfgCoarseWidth,
               cfgLastPattern, cfgPatternLength, patRdData,
        input  cfgBusy, cfgDone, cfgError, patRdAddr, csrStrobe, csrData
    );

    // Sequencer side.
    modport slave (
        input  cfgStart, cfgMode, cfgCoarseDelay, cfgFirstPattern, cfgCoarseWidth,
               cfgLastPattern, cfgPatternLength, patRdData,
        output cfgBusy, cfgDone, cfgError, patRdAddr, csrStrobe, csrData
    );
endinterface

// File: rtl/output_driver_cfg_sequencer.sv
// Turns one output-driver config request into a burst of CSR writes: DISABLE, DELAY, WIDTH, PATTERN x N, MODE.
// Latency: first strobe 1 cycle after accept, strobes WRITE_GAP+1 apart, cfgDone WRITE_GAP+1 after the last strobe.
// Backpressure: no ready; a request while busy or with an illegal pattern length is dropped with a cfgError pulse.
module output_driver_cfg_sequencer #(
    parameter int SERDES_WIDTH          = 4,
    parameter int COARSE_DELAY_WIDTH    = 22,
    parameter int COARSE_WIDTH_WIDTH    = 22,
    parameter int PATTERN_ADDRESS_WIDTH = 12,
    parameter int WRITE_GAP             = 2
) (
    input  logic                          sysClk,
    input  logic                          sysReset_n,
    output_driver_cfg_sequencer_if.slave  bus
);
    localparam int PAW = PATTERN_ADDRESS_WIDTH;
    localparam int GW  = (WRITE_GAP < 2) ? 1 : $clog2(WRITE_GAP + 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(WRITE_GAP);
    localparam logic [PAW:0]  MAX_LEN  = {1'b1, {PAW{1'b0}}};
    localparam logic [PAW:0]  PAT_ONE  = (PAW+1)'(1);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] WR_DISABLE = 3'd1;
    localparam logic [2:0] WR_DELAY   = 3'd2;
    localparam logic [2:0] WR_WIDTH   = 3'd3;
    localparam logic [2:0] WR_PATTERN = 3'd4;
    localparam logic [2:0] WR_MODE    = 3'd5;
    localparam logic [2:0] FINISH     = 3'd6;

    logic [2:0]                    state;
    logic [GW-1:0]                 gap;
    logic [1:0]                    mode_q;
    logic [COARSE_DELAY_WIDTH-1:0] delay_q;
    logic [SERDES_WIDTH-1:0]       first_q;
    logic [COARSE_WIDTH_WIDTH-1:0] width_q;
    logic [SERDES_WIDTH-1:0]       last_q;
    logic [PAW:0]                  len_q;
    logic [PAW:0]                  pat_idx;   // index of the next pattern word to write
    logic                          busy;
    logic                          done;
    logic                          err;
    logic                          strobe;
    logic [31:0]                   data;
    logic [PAW-1:0]                rd_addr;

    logic                          req_bad;
    logic                          want_pattern;
    logic [PAW:0]                  pat_next;
    logic [31:0]                   delay_word;
    logic [31:0]                   width_word;
    logic [31:0]                   pat_word;
    logic [31:0]                   mode_word;

    // Pattern modes need 1..2**PAW words; other modes ignore the length.
    assign req_bad = bus.cfgMode[1] &&
                     ((bus.cfgPatternLength == '0) || (bus.cfgPatternLength > MAX_LEN));

    assign pat_next     = pat_idx + PAT_ONE;
    assign want_pattern = ((state == WR_WIDTH) && mode_q[1]) ||
                          ((state == WR_PATTERN) && (pat_idx != len_q));

    assign delay_word = {2'b01, 30'({delay_q, first_q})};
    assign width_word = {2'b10, 30'({width_q, last_q})};
    assign pat_word   = {2'b11, 30'({pat_idx[PAW-1:0], 10'b0}) | 30'(bus.patRdData)};
    assign mode_word  = {30'b0, mode_q};

    // Sequencer FSM: one strobe, then WRITE_GAP idle cycles, then the next step is decided.
    // The RAM address for word i+1 is presented when word i is written, so the read completes inside the gap.
    always_ff @(posedge sysClk or negedge sysReset_n) begin
        if (!sysReset_n) begin
            state   <= IDLE;
            gap     <= '0;
            mode_q  <= '0;
            delay_q <= '0;
            first_q <= '0;
            width_q <= '0;
            last_q  <= '0;
            len_q   <= '0;
            pat_idx <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            strobe  <= 1'b0;
            data    <= '0;
            rd_addr <= '0;
        end else begin
            strobe <= 1'b0;
            data   <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
            if ((state == IDLE) || (state == FINISH)) begin
                state <= IDLE;
                if (bus.cfgStart) begin
                    if (req_bad) begin
                        err <= 1'b1;
                    end else begin
                        mode_q  <= bus.cfgMode;
                        delay_q <= bus.cfgCoarseDelay;
                        first_q <= bus.cfgFirstPattern;
                        width_q <= bus.cfgCoarseWidth;
                        last_q  <= bus.cfgLastPattern;
                        len_q   <= bus.cfgPatternLength;
                        pat_idx <= '0;
                        rd_addr <= '0;
                        busy    <= 1'b1;
                        state   <= WR_DISABLE;
                        strobe  <= 1'b1;
                        data    <= '0;
                        gap     <= GAP_LOAD;
                    end
                end
            end else begin
                if (bus.cfgStart) begin
                    err <= 1'b1;
                end
                if (gap != '0) begin
                    gap <= gap - GW'(1);
                end else if (want_pattern) begin
                    state   <= WR_PATTERN;
                    strobe  <= 1'b1;
                    data    <= pat_word;
                    gap     <= GAP_LOAD;
                    pat_idx <= pat_next;
                    if (pat_next != len_q) begin
                        rd_addr <= pat_next[PAW-1:0];
                    end
                end else begin
                    case (state)
                        WR_DISABLE: begin
                            if (mode_q == 2'd0) begin
                                state <= FINISH;
                                done  <= 1'b1;
                                busy  <= 1'b0;
                            end else begin
                                state  <= WR_DELAY;
                                strobe <= 1'b1;
                                data   <= delay_word;
                                gap    <= GAP_LOAD;
                            end
                        end
                        WR_DELAY: begin
                            state  <= WR_WIDTH;
                            strobe <= 1'b1;
                            data   <= width_word;
                            gap    <= GAP_LOAD;
                        end
                        WR_WIDTH, WR_PATTERN: begin
                            state  <= WR_MODE;
                            strobe <= 1'b1;
                            data   <= mode_word;
                            gap    <= GAP_LOAD;
                        end
                        default: begin
                            state <= FINISH;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign bus.cfgBusy   = busy;
    assign bus.cfgDone   = done;
    assign bus.cfgError  = err;
    assign bus.patRdAddr = rd_addr;
    assign bus.csrStrobe = strobe;
    assign bus.csrData   = data;
endmodule
